// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter that shares the single write port of
// an enable/sync-clear register among NUM_REQ requesters.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   req       per-requester request, held until ack
//   clr_req   per-requester op select (1 = clear, 0 = write)
//   wdata     packed write data, requester i at [i*MAX_WIDTH +: MAX_WIDTH]
//   ack       one-hot pulse in the winner's commit cycle
//   reg_ena   register enable (commit strobe)
//   reg_sclr  register synchronous clear
//   reg_d     register data (zero on clear)
//   grant_id  index of the requester being committed, 0 when idle
//   busy      copy of reg_ena
module reg_write_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            clr_req,
  input  logic [NUM_REQ*MAX_WIDTH-1:0]  wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          reg_ena,
  output logic                          reg_sclr,
  output logic [MAX_WIDTH-1:0]          reg_d,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  // One extra bit so ptr + offset never overflows before the wrap subtraction.
  localparam int unsigned SUM_W = ID_W + 1;
  localparam logic [SUM_W-1:0] NUM_REQ_S = SUM_W'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]      ptr;
  logic [NUM_REQ-1:0]   elig;
  logic [SUM_W-1:0]     sum;
  logic [ID_W-1:0]      idx;
  logic                 win_vld;
  logic [ID_W-1:0]      win_id;
  logic                 win_clr;
  logic [MAX_WIDTH-1:0] win_d;
  logic [MAX_WIDTH-1:0] wd [NUM_REQ];

  // Unpack the per-requester write data words.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign wd[g] = wdata[g*MAX_WIDTH +: MAX_WIDTH];
  end

  // Round-robin scan starting at ptr; a requester being acked this cycle is masked.
  always_comb begin
    elig    = req & ~ack;
    sum     = '0;
    idx     = '0;
    win_vld = 1'b0;
    win_id  = '0;
    win_clr = 1'b0;
    win_d   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + SUM_W'(i);
      if (sum >= NUM_REQ_S) begin
        sum = sum - NUM_REQ_S;
      end
      idx = sum[ID_W-1:0];
      if (!win_vld && elig[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
        win_clr = clr_req[idx];
        win_d   = wd[idx];
      end
    end
  end

  // Commit stage and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      ack      <= '0;
      reg_ena  <= 1'b0;
      reg_sclr <= 1'b0;
      reg_d    <= '0;
      grant_id <= '0;
    end else if (win_vld) begin
      ptr      <= (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
      ack      <= NUM_REQ'(1) << win_id;
      reg_ena  <= 1'b1;
      reg_sclr <= win_clr;
      reg_d    <= win_clr ? '0 : win_d;
      grant_id <= win_id;
    end else begin
      ack      <= '0;
      reg_ena  <= 1'b0;
      reg_sclr <= 1'b0;
      reg_d    <= '0;
      grant_id <= '0;
    end
  end

  assign busy = reg_ena;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter (NUM_REQ=4, MAX_WIDTH=8).
// Stimulus runs on the falling edge and queues the expected commit-stage
// outputs for the next rising edge; the monitor compares 1 time unit after
// every rising edge while out of reset.
module tb_reg_write_arbiter;

  typedef struct packed {
    logic [3:0] ack;
    logic       ena;
    logic       sclr;
    logic [7:0] d;
    logic [1:0] gid;
    logic       busy;
  } obs_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  clr_req;
  logic [31:0] wdata;
  logic [3:0]  ack;
  logic        reg_ena;
  logic        reg_sclr;
  logic [7:0]  reg_d;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  tgt;

  obs_t  sbq[$];
  string nameq[$];
  int    total;
  int    bad;

  reg_write_arbiter #(.NUM_REQ(4), .MAX_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .clr_req  (clr_req),
    .wdata    (wdata),
    .ack      (ack),
    .reg_ena  (reg_ena),
    .reg_sclr (reg_sclr),
    .reg_d    (reg_d),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the target enable/sync-clear register.
  always @(posedge clk or posedge rst) begin
    if (rst) tgt <= 8'h00;
    else if (reg_ena) tgt <= reg_sclr ? 8'h00 : reg_d;
  end

  function automatic obs_t mk(input logic [3:0] a, input logic s,
                              input logic [7:0] d, input logic [1:0] g);
    obs_t o;
    o.ack  = a;
    o.ena  = |a;
    o.sclr = s;
    o.d    = d;
    o.gid  = g;
    o.busy = |a;
    return o;
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o.ack  = ack;
    o.ena  = reg_ena;
    o.sclr = reg_sclr;
    o.d    = reg_d;
    o.gid  = grant_id;
    o.busy = busy;
    return o;
  endfunction

  task automatic chk(input string nm, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got ack=%b ena=%b sclr=%b d=%h gid=%0d busy=%b, want ack=%b ena=%b sclr=%b d=%h gid=%0d busy=%b",
               nm, $time, act.ack, act.ena, act.sclr, act.d, act.gid, act.busy,
               exp.ack, exp.ena, exp.sclr, exp.d, exp.gid, exp.busy);
    end
  endtask

  task automatic chk_tgt(input string nm, input logic [7:0] exp);
    total++;
    if (tgt !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: register got %h want %h", nm, $time, tgt, exp);
    end
  endtask

  // Queue the expectation for the next rising edge, then advance one cycle.
  task automatic step(input string nm, input obs_t e);
    sbq.push_back(e);
    nameq.push_back(nm);
    @(negedge clk);
  endtask

  // Monitor: one comparison per rising edge while a result is expected.
  initial begin
    obs_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (sbq.size() > 0) begin
          e  = sbq.pop_front();
          nm = nameq.pop_front();
          chk(nm, cur(), e);
        end else if (reg_ena) begin
          total++;
          bad++;
          $display("FAIL unexpected_commit t=%0t: got ena=1 gid=%0d ack=%b, want no commit",
                   $time, grant_id, ack);
        end
      end
    end
  end

  initial begin
    logic [7:0] wd_tab [4];
    obs_t idle;
    idle  = mk(4'b0000, 1'b0, 8'h00, 2'd0);
    total = 0;
    bad   = 0;
    wd_tab[0] = 8'h11; wd_tab[1] = 8'h22; wd_tab[2] = 8'h33; wd_tab[3] = 8'h44;

    // Reset held with all requesters active: outputs stay zero.
    rst     = 1'b1;
    req     = 4'b1111;
    clr_req = 4'b0000;
    wdata   = 32'h44332211;
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", cur(), idle);
    end

    // Full contention after release: 0,1,2,3,0,1,2,3.
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step("contention", mk(4'b0001 << (k % 4), 1'b0, wd_tab[k % 4], 2'(k % 4)));
    end
    req = 4'b0000;
    step("drain", idle);
    step("idle", idle);

    // Single write; req held past ack is masked one cycle then re-granted.
    req   = 4'b0001;
    wdata = 32'h443322A5;
    step("write_a5", mk(4'b0001, 1'b0, 8'hA5, 2'd0));
    step("ack_mask", idle);
    step("rewrite_a5", mk(4'b0001, 1'b0, 8'hA5, 2'd0));
    req = 4'b0000;
    step("idle", idle);
    chk_tgt("reg_after_write", 8'hA5);

    // Clear from requester 2 ignores its data word.
    req     = 4'b0100;
    clr_req = 4'b0100;
    wdata   = 32'h44FF22A5;
    step("clear", mk(4'b0100, 1'b1, 8'h00, 2'd2));
    req     = 4'b0000;
    clr_req = 4'b0000;
    step("idle", idle);
    chk_tgt("reg_after_clear", 8'h00);

    // Wrap: ptr=3, requesters 3 and 0 -> 3 then 0.
    wdata = 32'h44332211;
    req   = 4'b1001;
    step("wrap_3", mk(4'b1000, 1'b0, 8'h44, 2'd3));
    req = 4'b0001;
    step("wrap_0", mk(4'b0001, 1'b0, 8'h11, 2'd0));
    req = 4'b0000;
    step("idle", idle);

    // ptr must now be 1: requesters 0 and 1 -> 1 wins.
    req = 4'b0011;
    step("ptr_after_wrap", mk(4'b0010, 1'b0, 8'h22, 2'd1));

    // Reset mid-commit (reg_ena=1, grant_id=1): outputs drop asynchronously.
    req = 4'b0010;
    rst = 1'b1;
    #1;
    chk("async_reset", cur(), idle);
    @(negedge clk);
    chk("reset_hold2", cur(), idle);

    // Held req[1] is committed right after release.
    rst = 1'b0;
    step("post_reset", mk(4'b0010, 1'b0, 8'h22, 2'd1));
    req = 4'b0000;
    step("idle", idle);
    step("idle", idle);
    repeat (2) @(negedge clk);

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
